// File: rtl/deserialize_request.sv
// Reassembles five 128-bit stream beats into one 539-bit request and holds it until consumed.
// Optional macro DESERIALIZE_RESYNC_EN lets axis_tuser realign framing to a frame start.
module deserialize_request (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [127:0] axis_data,
  input  logic         axis_valid,
  input  logic         axis_tuser,
  output logic         axis_ready,
  output logic [538:0] request_data,
  output logic         request_valid,
  input  logic         request_ready
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t     state, state_next;
  logic [2:0] beat_idx, beat_idx_next;
  logic       running;
  logic       beat_fire;
  logic       store_en;
  logic [2:0] store_idx;
  logic       unused_tuser;

  assign unused_tuser = axis_tuser;

  // running stays low through reset so axis_ready only rises on the first edge after release
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= ACCUM;
      beat_idx <= 3'd0;
      running  <= 1'b0;
    end else begin
      state    <= state_next;
      beat_idx <= beat_idx_next;
      running  <= 1'b1;
    end
  end

  assign axis_ready    = running && (state == ACCUM);
  assign request_valid = (state == HOLD);
  assign beat_fire     = axis_valid && axis_ready;

  always_comb begin
    state_next    = state;
    beat_idx_next = beat_idx;
    store_en      = 1'b0;
    store_idx     = beat_idx;
    case (state)
      ACCUM: begin
        if (beat_fire) begin
`ifdef DESERIALIZE_RESYNC_EN
          // a tagged beat always restarts the frame; untagged beats at index 0 are strays
          if (axis_tuser) begin
            store_en      = 1'b1;
            store_idx     = 3'd0;
            beat_idx_next = 3'd1;
          end else if (beat_idx != 3'd0) begin
            store_en = 1'b1;
            if (beat_idx == 3'd4) begin
              beat_idx_next = 3'd0;
              state_next    = HOLD;
            end else begin
              beat_idx_next = beat_idx + 3'd1;
            end
          end
`else
          store_en = 1'b1;
          if (beat_idx == 3'd4) begin
            beat_idx_next = 3'd0;
            state_next    = HOLD;
          end else begin
            beat_idx_next = beat_idx + 3'd1;
          end
`endif
        end
      end
      HOLD: begin
        if (request_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // the last beat only contributes its low 27 bits
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      request_data <= '0;
    end else if (store_en) begin
      case (store_idx)
        3'd0:    request_data[127:0]   <= axis_data;
        3'd1:    request_data[255:128] <= axis_data;
        3'd2:    request_data[383:256] <= axis_data;
        3'd3:    request_data[511:384] <= axis_data;
        3'd4:    request_data[538:512] <= axis_data[26:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_deserialize_request.sv
// Scoreboard bench for deserialize_request: a queue-based frame model predicts each request,
// and an independent monitor checks every presented request against it.
module tb_deserialize_request;

  logic         clk_in;
  logic         rst_in;
  logic [127:0] axis_data;
  logic         axis_valid;
  logic         axis_tuser;
  logic         axis_ready;
  logic [538:0] request_data;
  logic         request_valid;
  logic         request_ready;

  typedef struct {
    logic [538:0] data;
    int           cyc;
  } exp_t;

  exp_t         expq[$];
  logic [127:0] pend[$];
  int           checks = 0;
  int           fails = 0;
  int           cyc = 0;
  int           ready_mode = 1;
  logic         prev_valid = 1'b0;

  deserialize_request dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .axis_data     (axis_data),
    .axis_valid    (axis_valid),
    .axis_tuser    (axis_tuser),
    .axis_ready    (axis_ready),
    .request_data  (request_data),
    .request_valid (request_valid),
    .request_ready (request_ready)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // mode 0: random, 1: always ready, 2: stalled
  always @(posedge clk_in) begin
    #1;
    case (ready_mode)
      0:       request_ready = ($urandom_range(0, 3) != 0);
      1:       request_ready = 1'b1;
      default: request_ready = 1'b0;
    endcase
  end

  task automatic check_output(input string name, input logic [538:0] act, input logic [538:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // reference: collect accepted beats, a request exists once five belong to one frame
  function automatic void model_accept(input logic [127:0] d, input logic t);
    exp_t e;
`ifdef DESERIALIZE_RESYNC_EN
    if (t) begin
      pend.delete();
      pend.push_back(d);
    end else if (pend.size() != 0) begin
      pend.push_back(d);
    end
`else
    pend.push_back(d);
`endif
    if (pend.size() == 5) begin
      e.data = {pend[4][26:0], pend[3], pend[2], pend[1], pend[0]};
      e.cyc  = cyc + 1;
      expq.push_back(e);
      pend.delete();
    end
  endfunction

  always @(negedge clk_in) begin
    if (rst_in && request_valid) begin
      if (expq.size() == 0) begin
        check_output("spurious_valid", 539'(request_valid), 539'(0));
      end else begin
        check_output("request_data", request_data, expq[0].data);
        check_output("ready_in_hold", 539'(axis_ready), 539'(0));
        if (!prev_valid) check_output("valid_latency", 539'(cyc), 539'(expq[0].cyc));
        if (request_ready) void'(expq.pop_front());
      end
    end
    prev_valid = request_valid;
  end

  task automatic send_beat(input logic [127:0] d, input logic t, input int gap);
    bit accepted = 0;
    axis_valid = 1'b1;
    axis_data  = d;
    axis_tuser = t;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk_in);
      if (axis_ready) begin
        accepted = 1;
        model_accept(d, t);
      end
      @(posedge clk_in);
      #1;
    end
    if (!accepted) check_output("beat_accept_timeout", 539'(0), 539'(1));
    axis_valid = 1'b0;
    axis_data  = {$urandom, $urandom, $urandom, $urandom};
    axis_tuser = $urandom_range(0, 1);
    repeat (gap) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic send_frame(input int gap);
    for (int k = 0; k < 5; k++)
      send_beat({$urandom, $urandom, $urandom, $urandom}, (k == 0), gap);
  endtask

  task automatic apply_reset();
    axis_valid = 1'b0;
    rst_in     = 1'b0;
    pend.delete();
    expq.delete();
    prev_valid = 1'b0;
    @(negedge clk_in);
    check_output("reset_ready", 539'(axis_ready), 539'(0));
    check_output("reset_valid", 539'(request_valid), 539'(0));
    check_output("reset_data", request_data, 539'(0));
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    check_output("ready_after_reset", 539'(axis_ready), 539'(1));
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && expq.size() != 0; i++) @(posedge clk_in);
    #1;
    check_output("drain_pending", 539'(expq.size()), 539'(0));
  endtask

  initial begin
    rst_in        = 1'b0;
    axis_valid    = 1'b0;
    axis_data     = '0;
    axis_tuser    = 1'b0;
    request_ready = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    apply_reset();

    $display("[TB] back-to-back frame with small beat values");
    ready_mode = 1;
    for (int k = 0; k < 5; k++)
      send_beat({$urandom, $urandom, $urandom, 32'(k)}, (k == 0), 0);
    drain();

    $display("[TB] consumer stalled after completion");
    ready_mode = 2;
    send_frame(0);
    repeat (12) @(posedge clk_in);
    #1;
    check_output("stall_still_pending", 539'(expq.size()), 539'(1));
    ready_mode = 1;
    drain();

    $display("[TB] valid toggling every cycle");
    send_frame(1);
    drain();

    $display("[TB] reset mid-frame then fresh frame");
    for (int k = 0; k < 3; k++) send_beat({$urandom, $urandom, $urandom, $urandom}, (k == 0), 0);
    apply_reset();
    send_frame(0);
    drain();

    $display("[TB] reset while holding a request");
    ready_mode = 2;
    send_frame(0);
    repeat (3) @(posedge clk_in);
    #1;
    apply_reset();
    ready_mode = 1;
    repeat (4) @(posedge clk_in);
    #1;
    check_output("no_valid_after_reset", 539'(request_valid), 539'(0));

    $display("[TB] two beats, tagged beat, four beats");
    for (int k = 0; k < 7; k++)
      send_beat({$urandom, $urandom, $urandom, $urandom}, (k == 0 || k == 2), 0);
    drain();
    apply_reset();

    $display("[TB] three untagged strays then a frame");
    for (int k = 0; k < 3; k++) send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0);
    send_frame(0);
    drain();
    apply_reset();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 300; n++) begin
      logic t;
      ready_mode = $urandom_range(0, 1);
      t = (pend.size() == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      send_beat({$urandom, $urandom, $urandom, $urandom}, t, $urandom_range(0, 2));
    end
    ready_mode = 1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/deserialize_request.md
DESERIALIZE_REQUEST -- requirements
Module: deserialize_request

Interface
REQ-001: Parameters: none; widths fixed at 128-bit stream and 539-bit request.
REQ-002: clk_in  input  1  single clock; all state is updated on the rising edge.
REQ-003: rst_in  input  1  reset, asynchronous assert, active-low.
REQ-004: axis_data  input  128  stream beat payload.
REQ-005: axis_valid  input  1  beat present.
REQ-006: axis_tuser  input  1  marks the first beat of a request frame.
REQ-007: axis_ready  output  1  block accepts a beat this cycle.
REQ-008: request_data  output  539  reassembled request.
REQ-009: request_valid  output  1  request_data is valid.
REQ-010: request_ready  input  1  consumer accepts the request.

Function
REQ-011: A frame SHALL be exactly 5 beats; beat k (k=0..4) SHALL carry request bits [128k+127:128k]; beat 4 SHALL supply bits 538:512 from axis_data[26:0], and axis_data[127:27] of beat 4 SHALL be ignored.
REQ-012: A beat SHALL be accepted only on a cycle with axis_valid=1 and axis_ready=1.
REQ-013: The block SHALL have two states, ACCUM and HOLD, plus a 3-bit beat index in the range 0..4.
REQ-014: In ACCUM, axis_ready SHALL be 1 and request_valid SHALL be 0.
REQ-015: In ACCUM, each accepted beat SHALL be written into the slice selected by the beat index, and the beat index SHALL then increment.
REQ-016: When beat index 4 is accepted, the beat index SHALL wrap to 0 and the state SHALL move to HOLD on the same edge.
REQ-017: In HOLD, request_valid SHALL be 1, axis_ready SHALL be 0, and request_data SHALL be stable.
REQ-018: In HOLD with request_ready=1, the state SHALL return to ACCUM on that edge; the next frame's beat 0 SHALL be accepted no earlier than the following cycle.
REQ-019: Latency SHALL be: request_valid rises on the first cycle after the beat-4 handshake. Minimum period SHALL be 6 cycles per frame.
REQ-020: request_ready SHALL be ignored in ACCUM.
REQ-021: axis_data and axis_tuser SHALL be ignored on any cycle without a handshake.
REQ-022: Slices of request_data not overwritten by a frame SHALL retain their prior values; no partial frame SHALL ever produce request_valid.

Reset
REQ-023: While rst_in=0, the block SHALL be in state ACCUM with beat index 0, request_data=0, request_valid=0 and axis_ready=0.
REQ-024: On the first clock edge after rst_in returns to 1, axis_ready SHALL be 1.
REQ-025: A reset asserted mid-frame or in HOLD SHALL discard all partial or pending data immediately; the pending request SHALL NOT be presented after reset.

Configuration
REQ-026: Macro DESERIALIZE_RESYNC_EN.
REQ-027: Without the macro, axis_tuser SHALL be ignored and framing SHALL be purely positional.
REQ-028: With the macro, an accepted beat with axis_tuser=1 SHALL be stored as beat 0 and SHALL set the beat index to 1, discarding any partial frame.
REQ-029: With the macro, an accepted beat with axis_tuser=0 while the beat index is 0 SHALL be discarded, and the beat index SHALL stay 0.
REQ-030: With the macro, an accepted beat with axis_tuser=1 at index 4 SHALL restart the frame and SHALL NOT complete it.

Verification
REQ-031: Back-to-back stream of 5 beats 0x..00,0x..01,..,0x..04 (tuser on beat 0), request_ready=1 -> request_valid for exactly 1 cycle, on the cycle after beat 4; request_data[538:512]=27'h0000004 and request_data[127:0]=beat 0.
REQ-032: request_ready held 0 for 10 cycles after the frame completes -> request_valid stays 1, axis_ready stays 0, and request_data is unchanged throughout.
REQ-033: axis_valid toggling 1/0 every cycle over 5 beats -> exactly one request, and beat order is preserved.
REQ-034: rst_in pulsed low after beat 2, then a full fresh frame -> the first request contains only the fresh frame's data.
REQ-035: With DESERIALIZE_RESYNC_EN, send 2 beats, then a tuser=1 beat, then 4 beats -> one request built from the last 5 beats. Without the macro, the same stimulus -> one request built from the first 5 beats.
REQ-036: With DESERIALIZE_RESYNC_EN, 3 beats with tuser=0 while idle, then a valid frame -> the 3 stray beats are accepted and dropped, and the request matches the frame.
